// File: rtl/knn_pkg.sv
// Shared constants for the streaming k-nearest-neighbour engine.
package knn_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Wide enough for DATA_W up to 126; users slice it down to DIST_W.
    localparam int                    MAX_DIST_W = 255;
    localparam logic [MAX_DIST_W-1:0] DIST_EMPTY = '1;

    function automatic int dist_w(input int data_w);
        return 2 * data_w + 3;
    endfunction

endpackage

// File: rtl/knn_sqdist.sv
// Two-stage signed squared-distance datapath: S1 differences, S2 sum of squares.
module knn_sqdist
    import knn_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int LABEL_W = 8,
    localparam int DIST_W  = dist_w(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  qx,
    input  logic [DATA_W-1:0]  qy,
    input  logic [DATA_W-1:0]  px,
    input  logic [DATA_W-1:0]  py,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               out_valid,
    output logic [DIST_W-1:0]  out_dist,
    output logic [LABEL_W-1:0] out_label,
    output logic               out_last
);
    localparam int STAGES = 2;

    logic [STAGES:1]            vld_pipe;
    logic signed [DATA_W:0]     dx_c, dy_c, s1_dx, s1_dy;
    logic signed [2*DATA_W+1:0] dx_w, dy_w, sq_x, sq_y;
    logic [LABEL_W-1:0]         s1_label;
    logic                       s1_last;

    assign dx_c = $signed({px[DATA_W-1], px}) - $signed({qx[DATA_W-1], qx});
    assign dy_c = $signed({py[DATA_W-1], py}) - $signed({qy[DATA_W-1], qy});

    // Widen before multiplying so the product is exact at 2*DATA_W+2 bits.
    assign dx_w = $signed({{(DATA_W+1){s1_dx[DATA_W]}}, s1_dx});
    assign dy_w = $signed({{(DATA_W+1){s1_dy[DATA_W]}}, s1_dy});
    assign sq_x = dx_w * dx_w;
    assign sq_y = dy_w * dy_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_label  <= '0;
            s1_last   <= 1'b0;
            out_dist  <= '0;
            out_label <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            vld_pipe  <= flush ? '0 : {vld_pipe[1], in_valid};
            s1_dx     <= dx_c;
            s1_dy     <= dy_c;
            s1_label  <= in_label;
            s1_last   <= in_last;
            out_dist  <= {1'b0, sq_x} + {1'b0, sq_y};
            out_label <= s1_label;
            out_last  <= s1_last;
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: rtl/knn_topk.sv
// Streaming k-NN engine: FSM, query latch and the sorted K-entry neighbour list.
module knn_topk
    import knn_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int K       = 4,
    parameter  int LABEL_W = 8,
    localparam int DIST_W  = dist_w(DATA_W),
    localparam int CNT_W   = $clog2(K + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   KNN_ENABLE,
    input  logic                   start,
    input  logic [DATA_W-1:0]      qx,
    input  logic [DATA_W-1:0]      qy,
    input  logic                   pt_valid,
    input  logic [DATA_W-1:0]      px,
    input  logic [DATA_W-1:0]      py,
    input  logic [LABEL_W-1:0]     pt_label,
    input  logic                   pt_last,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       count,
    output logic [K*DIST_W-1:0]    nb_dist,
    output logic [K*LABEL_W-1:0]   nb_label
);
    localparam logic [DIST_W-1:0] EMPTY = DIST_EMPTY[DIST_W-1:0];

    logic [1:0]         state;
    logic [DATA_W-1:0]  q_x, q_y;
    logic [DIST_W-1:0]  nb_d   [K];
    logic [LABEL_W-1:0] nb_l   [K];
    logic [DIST_W-1:0]  nxt_d  [K];
    logic [LABEL_W-1:0] nxt_l  [K];
    logic [K-1:0]       lt;
    logic               accept;
    logic               s2_valid, s2_last;
    logic [DIST_W-1:0]  s2_dist;
    logic [LABEL_W-1:0] s2_label;

    assign accept = pt_valid && (state == ST_RUN) && !start;
    assign busy   = (state == ST_RUN) || (state == ST_DRAIN);

    knn_sqdist #(.DATA_W(DATA_W), .LABEL_W(LABEL_W)) u_sqdist (
        .clk      (clk),
        .rst      (rst),
        .en       (KNN_ENABLE),
        .flush    (start),
        .in_valid (accept),
        .qx       (q_x),
        .qy       (q_y),
        .px       (px),
        .py       (py),
        .in_label (pt_label),
        .in_last  (pt_last),
        .out_valid(s2_valid),
        .out_dist (s2_dist),
        .out_label(s2_label),
        .out_last (s2_last)
    );

    // The list is ascending, so lt is a thermometer code: the first set bit is
    // the insertion slot, and strict compare puts ties after existing entries.
    for (genvar i = 0; i < K; i++) begin : g_ent
        assign lt[i] = s2_dist < nb_d[i];
        if (i == 0) begin : g_head
            assign nxt_d[i] = lt[i] ? s2_dist  : nb_d[i];
            assign nxt_l[i] = lt[i] ? s2_label : nb_l[i];
        end else begin : g_body
            assign nxt_d[i] = !lt[i] ? nb_d[i] : (lt[i-1] ? nb_d[i-1] : s2_dist);
            assign nxt_l[i] = !lt[i] ? nb_l[i] : (lt[i-1] ? nb_l[i-1] : s2_label);
        end
        assign nb_dist[i*DIST_W +: DIST_W]    = nb_d[i];
        assign nb_label[i*LABEL_W +: LABEL_W] = nb_l[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            q_x   <= '0;
            q_y   <= '0;
            count <= '0;
            done  <= 1'b0;
            for (int i = 0; i < K; i++) begin
                nb_d[i] <= EMPTY;
                nb_l[i] <= '0;
            end
        end else if (KNN_ENABLE) begin
            done <= 1'b0;
            if (start) begin
                state <= ST_RUN;
                q_x   <= qx;
                q_y   <= qy;
                count <= '0;
                for (int i = 0; i < K; i++) begin
                    nb_d[i] <= EMPTY;
                    nb_l[i] <= '0;
                end
            end else begin
                if (state == ST_RUN && pt_valid && pt_last)
                    state <= ST_DRAIN;
                if (s2_valid && lt[K-1]) begin
                    nb_d <= nxt_d;
                    nb_l <= nxt_l;
                    if (count != CNT_W'(K))
                        count <= count + 1'b1;
                end
                if (s2_valid && s2_last && state == ST_DRAIN) begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_knn_topk.sv
// Self-checking bench for knn_topk: table of streams plus stall/abort/reset sequences.
module tb_knn_topk;
    localparam int DW  = 32;
    localparam int K   = 4;
    localparam int LW  = 8;
    localparam int DSW = 2 * DW + 3;
    localparam int CW  = $clog2(K + 1);
    localparam logic [DSW-1:0] EMPTY = '1;

    logic              clk = 1'b0;
    logic              rst, en, start, pt_valid, pt_last;
    logic [DW-1:0]     qx, qy, px, py;
    logic [LW-1:0]     pt_label;
    logic              busy, done;
    logic [CW-1:0]     count;
    logic [K*DSW-1:0]  nb_dist;
    logic [K*LW-1:0]   nb_label;

    knn_topk #(.DATA_W(DW), .K(K), .LABEL_W(LW)) dut (
        .clk(clk), .rst(rst), .KNN_ENABLE(en), .start(start), .qx(qx), .qy(qy),
        .pt_valid(pt_valid), .px(px), .py(py), .pt_label(pt_label), .pt_last(pt_last),
        .busy(busy), .done(done), .count(count), .nb_dist(nb_dist), .nb_label(nb_label)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] qx, qy;
        int                   n;
        logic signed [DW-1:0] px [6];
        logic signed [DW-1:0] py [6];
        logic [LW-1:0]        lb [6];
        int                   ecnt;
        logic [DSW-1:0]       ed [K];
        logic [LW-1:0]        el [K];
    } vec_t;

    vec_t vecs [5];
    int   exp_q [$];
    int   checks = 0, errors = 0;
    int   done_cnt = 0;
    logic done_d = 1'b0;

    always @(negedge clk) begin
        if (done && !done_d) done_cnt++;
        done_d = done;
    end

    task automatic chk(input string nm, input logic [DSW-1:0] act, input logic [DSW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DSW-1:0] get_d(input int i);
        return nb_dist[i*DSW +: DSW];
    endfunction

    function automatic logic [LW-1:0] get_l(input int i);
        return nb_label[i*LW +: LW];
    endfunction

    // Start cycle also presents a zero-distance point that must be ignored.
    task automatic do_start(input int v);
        @(posedge clk); #1;
        start = 1'b1; qx = vecs[v].qx; qy = vecs[v].qy;
        pt_valid = 1'b1; px = vecs[v].qx; py = vecs[v].qy; pt_label = 8'hEE; pt_last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_clears_count", count, 0);
    endtask

    task automatic send_pts(input int v, input int upto, input int stall_at);
        for (int i = 0; i < upto; i++) begin
            if (i == stall_at) begin
                en = 1'b0; pt_valid = 1'b0;
                repeat (5) @(posedge clk);
                #1 en = 1'b1;
            end
            pt_valid = 1'b1; px = vecs[v].px[i]; py = vecs[v].py[i];
            pt_label = vecs[v].lb[i]; pt_last = (i == vecs[v].n - 1);
            if (i != upto - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic finish_stream(input int v, input bit check_lat);
        int lat, idx;
        bit got;
        exp_q.push_back(v);
        lat = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge clk); #1;
            lat++;
            pt_valid = 1'b0; pt_last = 1'b0;
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: stream %0d no done within 20 cycles", v);
            void'(exp_q.pop_front());
            return;
        end
        idx = exp_q.pop_front();
        if (check_lat) chk("done_latency", lat, 3);
        chk("count", count, vecs[idx].ecnt);
        for (int i = 0; i < K; i++) begin
            chk($sformatf("s%0d_dist%0d", idx, i), get_d(i), vecs[idx].ed[i]);
            chk($sformatf("s%0d_label%0d", idx, i), get_l(i), vecs[idx].el[i]);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin
        logic [DSW-1:0] e;
        int d0, lat;
        bit got;

        e = 67'h0_FFFF_FFFF;
        vecs[0].qx = 0; vecs[0].qy = 0; vecs[0].n = 5;
        vecs[0].px = '{3, 1, 10, 0, 5, 0}; vecs[0].py = '{4, 1, 0, 2, 5, 0};
        vecs[0].lb = '{1, 2, 3, 4, 5, 0};
        vecs[0].ecnt = 4; vecs[0].ed = '{2, 4, 25, 50}; vecs[0].el = '{2, 4, 1, 5};

        vecs[1].qx = 0; vecs[1].qy = 0; vecs[1].n = 3;
        vecs[1].px = '{1, 0, -1, 0, 0, 0}; vecs[1].py = '{0, 1, 0, 0, 0, 0};
        vecs[1].lb = '{8'hA, 8'hB, 8'hC, 0, 0, 0};
        vecs[1].ecnt = 3; vecs[1].ed = '{1, 1, 1, EMPTY}; vecs[1].el = '{8'hA, 8'hB, 8'hC, 0};

        vecs[2].qx = 32'sh8000_0000; vecs[2].qy = 32'sh8000_0000; vecs[2].n = 2;
        vecs[2].px = '{32'sh7FFF_FFFF, 32'sh8000_0000, 0, 0, 0, 0};
        vecs[2].py = '{32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 0, 0, 0, 0};
        vecs[2].lb = '{7, 6, 0, 0, 0, 0};
        vecs[2].ecnt = 2; vecs[2].ed = '{e * e, (e * e) << 1, EMPTY, EMPTY};
        vecs[2].el = '{6, 7, 0, 0};

        vecs[3].qx = -128; vecs[3].qy = -128; vecs[3].n = 2;
        vecs[3].px = '{127, -128, 0, 0, 0, 0}; vecs[3].py = '{127, -128, 0, 0, 0, 0};
        vecs[3].lb = '{9, 8, 0, 0, 0, 0};
        vecs[3].ecnt = 2; vecs[3].ed = '{0, 130050, EMPTY, EMPTY}; vecs[3].el = '{8, 9, 0, 0};

        vecs[4].qx = 5; vecs[4].qy = -3; vecs[4].n = 6;
        vecs[4].px = '{2, 5, -1, 6, 5, 8}; vecs[4].py = '{1, -3, -3, -2, -8, 1};
        vecs[4].lb = '{1, 2, 3, 4, 5, 6};
        vecs[4].ecnt = 4; vecs[4].ed = '{0, 2, 25, 25}; vecs[4].el = '{2, 4, 1, 5};

        rst = 1'b1; en = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0;
        qx = '0; qy = '0; px = '0; py = '0; pt_label = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        for (int i = 0; i < K; i++) begin
            chk("rst_dist", get_d(i), EMPTY);
            chk("rst_label", get_l(i), 0);
        end

        for (int v = 0; v < 5; v++) begin
            do_start(v);
            send_pts(v, vecs[v].n, -1);
            finish_stream(v, v == 0);
        end

        // Points while idle must not disturb the held results of stream 4.
        d0 = done_cnt;
        pt_valid = 1'b1; px = 5; py = -3; pt_label = 77; pt_last = 1'b1;
        repeat (4) @(posedge clk);
        #1 pt_valid = 1'b0; pt_last = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_pt_count", count, 4);
        chk("idle_pt_dist1", get_d(1), 2);
        chk("idle_pt_label0", get_l(0), 2);
        chk("idle_pt_busy", busy, 0);
        chk("idle_pt_no_done", done_cnt, d0);

        // Stall for 5 cycles mid-stream; results must match the plain run.
        do_start(0);
        send_pts(0, 5, 2);
        finish_stream(0, 1'b0);

        // Abort a partial stream with a new start.
        do_start(1);
        send_pts(1, 2, -1);
        @(posedge clk); #1 pt_valid = 1'b0;
        d0 = done_cnt;
        do_start(0);
        send_pts(0, 5, -1);
        finish_stream(0, 1'b0);
        chk("abort_single_done", done_cnt, d0 + 1);

        // done must hold while the engine is disabled.
        do_start(3);
        send_pts(3, 2, -1);
        lat = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge clk); #1;
            lat++; pt_valid = 1'b0; pt_last = 1'b0;
            if (done) got = 1'b1;
        end
        chk("stall_done_seen", got, 1);
        en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_done_held", done, 1);
        end
        en = 1'b1;
        @(posedge clk); #1;
        chk("stall_done_released", done, 0);
        chk("stall_count", count, 2);

        // Reset during DRAIN.
        do_start(0);
        send_pts(0, 5, -1);
        @(posedge clk); #1 pt_valid = 1'b0; pt_last = 1'b0;
        chk("drain_busy", busy, 1);
        rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1 rst = 1'b0;
        chk("drain_rst_busy", busy, 0);
        chk("drain_rst_count", count, 0);
        chk("drain_rst_dist0", get_d(0), EMPTY);
        chk("drain_rst_label0", get_l(0), 0);
        repeat (6) @(posedge clk);
        #1 chk("drain_rst_no_done", done_cnt, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
